ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Parametrised control-signal pipeline carrying the decoded control bundle from decode through STAGES downstream pipeline stages. It generalises the fixed E/M/W control registers with several additions: per-stage stall and flush, valid tracking, bubble insertion, per-stage field pruning masks, and a retired-instruction counter. It sits between the main/ALU control decoders and the datapath, and is driven by the hazard unit's stall and flush vectors.

## Interface
- W, 17: control bundle width in bits.
- STAGES, 3: number of pipeline stages after decode; stage 0 = execute, stage STAGES-1 = write back. Legal range 1..8.
- KEEP, all ones (STAGES*W bits): per-stage keep mask; stage k stores only the bits set in KEEP[k*W +: W], all others are forced to 0.
- CW, 32: retire counter width.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_d  in  W  control bundle from decode.
- valid_d  in  1  ctrl_d holds a real instruction.
- in_ready  out  1  decode bundle is consumed this cycle.
- stall  in  STAGES  stall[k] holds stage k.
- flush  in  STAGES  flush[k] turns stage k into a bubble.
- cnt_clr  in  1  clears the retire counter.
- ctrl_q  out  STAGES*W  stage k bundle at ctrl_q[k*W +: W].
- valid_q  out  STAGES  stage k valid.
- retire  out  1  last stage retires this cycle.
- retire_cnt  out  CW  count of retired instructions.

## Operation
- Effective hold: hold[k] = OR of stall[STAGES-1:k]. A stall freezes its own stage and every earlier stage.
- Per-stage next state, in priority order:
  - rst: ctrl = 0, valid = 0.
  - flush[k]: ctrl = 0, valid = 0. Flush wins over hold.
  - hold[k]: keep current contents.
  - Else, if k > 0 and hold[k-1]: load a bubble (ctrl = 0, valid = 0).
  - Else: load the upstream value masked by KEEP[k]. For k = 0 the upstream value is {ctrl_d, valid_d}; for k > 0 it is stage k-1.
- A bubble loaded from upstream, and any stage with valid = 0, always has ctrl = 0. Downstream never sees stale write enables.
- in_ready = ~hold[0]. This is combinational, independent of flush. If flush[0] and in_ready are both high, the input is consumed and discarded.
- retire = valid_q[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1]. This is combinational.
- retire_cnt increments by 1 on each retire and wraps from 2^CW-1 to 0.
  - cnt_clr forces it to 0. If cnt_clr and retire occur in the same cycle, the result is 0.
  - rst also forces it to 0.
- STAGES = 1: stage 0 loads directly from input; the bubble rule does not apply.

## Timing
- Reset values: ctrl_q = 0, valid_q = 0, retire_cnt = 0. With stall = 0 during reset, in_ready = 1 and retire = 0.
- Latency: a bundle accepted at edge t is visible in stage k after edge t+k, with no stalls.
- A stall asserted in cycle c freezes the affected stages at edge c+1. The first stage below the stall receives a bubble at that edge.
- A flush asserted in cycle c clears the stage at edge c+1, whether or not that stage is held.
- No combinational path from ctrl_d to ctrl_q. Combinational paths are stall → in_ready and stall/flush → retire only.
- Reset mid-stall or mid-flush: reset dominates. All stages are empty on the following cycle.

## Structure
- Package ctrl_pipe_pkg holds:
  - the default W, STAGES and CW constants;
  - the bit-position constants of the standard bundle (jal, jalr, lui, auipc, RW_type[2:0], aluctl[3:0], memtoreg, memread, memwrite, regwrite, alusrc);
  - the default E/M/W KEEP masks that reproduce the current pruning.
- One sub-module, ctrl_pipe_stage: a W+1 bit register with inputs rst, clear, hold, bubble and d. It is instantiated STAGES times in a generate loop. The retire counter stays in the top module.

## Test plan
Configuration for all scenarios: W=8, STAGES=3, KEEP all ones unless stated.
- Streaming: valid_d = 1 with ctrl_d = 0x11, 0x22, 0x33 on consecutive cycles, no stall. Stage 2 shows 0x11, 0x22, 0x33 on cycles 3, 4, 5. retire_cnt reaches 3.
- Stall with bubble: stall = 3'b010 for 2 cycles while 0xA5 is in stage 1.
  - Stages 0 and 1 freeze and in_ready = 0.
  - Stage 2 receives a bubble (valid 0, ctrl 0x00) for 2 cycles.
  - 0xA5 then reaches stage 2 one cycle after the stall is released.
- Flush over stall: flush = 3'b001 and stall = 3'b001 together, with 0x5C in stage 0. Next cycle stage 0 has valid 0 and ctrl 0x00. Stages 1 and 2 advance normally.
- Pruning: KEEP[stage 2] = 0x0F and ctrl_d = 0xFF. Stage 0 shows 0xFF, stage 1 shows 0xFF, stage 2 shows 0x0F.
- Counter wrap and clear: CW = 4, 17 retires gives retire_cnt = 1. cnt_clr asserted together with a retire gives 0.
- Reset mid-operation: rst high for 1 cycle with all stages valid and stall = 3'b100. All of valid_q, ctrl_q and retire_cnt are 0 on the next cycle.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the decoded control-bundle pipeline: default sizes,
// bit positions of the standard bundle, and the E/M/W pruning masks.
package ctrl_pipe_pkg;

  localparam int W_DEF      = 17;
  localparam int STAGES_DEF = 3;
  localparam int CW_DEF     = 32;

  localparam int B_ALUSRC    = 0;
  localparam int B_REGWRITE  = 1;
  localparam int B_MEMWRITE  = 2;
  localparam int B_MEMREAD   = 3;
  localparam int B_MEMTOREG  = 4;
  localparam int B_ALUCTL_LO = 5;
  localparam int B_ALUCTL_HI = 8;
  localparam int B_RWTYPE_LO = 9;
  localparam int B_RWTYPE_HI = 11;
  localparam int B_AUIPC     = 12;
  localparam int B_LUI       = 13;
  localparam int B_JALR      = 14;
  localparam int B_JAL       = 15;

  // Bit 16 is a spare slot so the bundle width matches the decoder output.
  typedef struct packed {
    logic       spare;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic [2:0] rw_type;
    logic [3:0] aluctl;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       alusrc;
  } ctrl_bundle_t;

  localparam logic [W_DEF-1:0] KEEP_E = '1;

  // Memory stage no longer needs ALU operand select or ALU opcode.
  localparam logic [W_DEF-1:0] KEEP_M =
      (W_DEF'(1) << B_JAL)      | (W_DEF'(1) << B_JALR)     |
      (W_DEF'(1) << B_LUI)      | (W_DEF'(1) << B_AUIPC)    |
      (W_DEF'(7) << B_RWTYPE_LO) |
      (W_DEF'(1) << B_MEMTOREG) | (W_DEF'(1) << B_MEMREAD)  |
      (W_DEF'(1) << B_MEMWRITE) | (W_DEF'(1) << B_REGWRITE);

  // Write back only selects the result source and the register write.
  localparam logic [W_DEF-1:0] KEEP_W =
      (W_DEF'(1) << B_JAL)      | (W_DEF'(1) << B_JALR)     |
      (W_DEF'(1) << B_LUI)      | (W_DEF'(1) << B_AUIPC)    |
      (W_DEF'(7) << B_RWTYPE_LO) |
      (W_DEF'(1) << B_MEMTOREG) | (W_DEF'(1) << B_REGWRITE);

  localparam logic [3*W_DEF-1:0] KEEP_EMW = {KEEP_W, KEEP_M, KEEP_E};

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline slot holding {valid, ctrl}. An empty slot always stores ctrl = 0
// so downstream logic never sees stale enables behind a cleared valid.
module ctrl_pipe_stage #(
  parameter int W = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hold,
  input  logic       bubble,
  input  logic [W:0] d,
  output logic [W:0] q
);

  logic [W:0] q_q;
  logic [W:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (hold) begin
      q_d = q_q;
    end else if (bubble) begin
      q_d = '0;
    end else if (d[W]) begin
      q_d = d;
    end else begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline from decode through STAGES stages with per-stage
// stall/flush, bubble insertion, field pruning and a retired-instruction counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int                     W      = W_DEF,
  parameter int                     STAGES = STAGES_DEF,
  parameter logic [STAGES*W-1:0]    KEEP   = '1,
  parameter int                     CW     = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        ctrl_d,
  input  logic                valid_d,
  output logic                in_ready,
  input  logic [STAGES-1:0]   stall,
  input  logic [STAGES-1:0]   flush,
  input  logic                cnt_clr,
  output logic [STAGES*W-1:0] ctrl_q,
  output logic [STAGES-1:0]   valid_q,
  output logic                retire,
  output logic [CW-1:0]       retire_cnt
);

  logic [STAGES-1:0] hold;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  // Handshake: decode offers {ctrl_d, valid_d} every cycle; it is consumed on
  // any cycle where in_ready is high, even if stage 0 is flushed that cycle.
  assign in_ready = ~hold[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W:0] up;
    logic [W:0] q_k;
    logic       bub;

    // A stall anywhere downstream freezes this stage too.
    assign hold[k] = |stall[STAGES-1:k];

    if (k == 0) begin : g_first
      assign up  = {valid_d, ctrl_d & KEEP[W-1:0]};
      assign bub = 1'b0;
    end else begin : g_rest
      assign up  = {valid_q[k-1], ctrl_q[(k-1)*W +: W] & KEEP[k*W +: W]};
      assign bub = hold[k-1];
    end

    ctrl_pipe_stage #(.W(W)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clear  (flush[k]),
      .hold   (hold[k]),
      .bubble (bub),
      .d      (up),
      .q      (q_k)
    );

    assign ctrl_q[k*W +: W] = q_k[W-1:0];
    assign valid_q[k]       = q_k[W];
  end

  assign retire = valid_q[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (retire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two 3-stage instances (full keep and pruned stage 2)
// plus a 1-stage instance, checked by directed tables and a random model run.
module tb_ctrl_pipe;

  logic       clk;
  logic       rst;
  logic [7:0] ctrl_d;
  logic       valid_d;
  logic [2:0] stall;
  logic [2:0] flush;
  logic       cnt_clr;
  logic [0:0] stall1;
  logic [0:0] flush1;

  logic        a_in_ready, a_retire;
  logic [23:0] a_ctrl_q;
  logic [2:0]  a_valid_q;
  logic [3:0]  a_retire_cnt;
  logic        b_in_ready, b_retire;
  logic [23:0] b_ctrl_q;
  logic [2:0]  b_valid_q;
  logic [3:0]  b_retire_cnt;
  logic        c_in_ready, c_retire;
  logic [7:0]  c_ctrl_q;
  logic [0:0]  c_valid_q;
  logic [3:0]  c_retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe #(.W(8), .STAGES(3), .KEEP(24'hFFFFFF), .CW(4)) dut_a (
    .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d), .in_ready(a_in_ready),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr), .ctrl_q(a_ctrl_q),
    .valid_q(a_valid_q), .retire(a_retire), .retire_cnt(a_retire_cnt));

  ctrl_pipe #(.W(8), .STAGES(3), .KEEP(24'h0FFFFF), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d), .in_ready(b_in_ready),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr), .ctrl_q(b_ctrl_q),
    .valid_q(b_valid_q), .retire(b_retire), .retire_cnt(b_retire_cnt));

  ctrl_pipe #(.W(8), .STAGES(1), .KEEP(8'hFF), .CW(4)) dut_c (
    .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d), .in_ready(c_in_ready),
    .stall(stall1), .flush(flush1), .cnt_clr(cnt_clr), .ctrl_q(c_ctrl_q),
    .valid_q(c_valid_q), .retire(c_retire), .retire_cnt(c_retire_cnt));

  // ---------------- reference model ----------------
  // Per instance: occupancy of each stage as {valid, ctrl}, plus the counter.
  logic       m_v[3][3];
  logic [7:0] m_c[3][3];
  logic [7:0] m_keep[3][3];
  logic [3:0] m_cnt[3];
  int         m_n[3];

  function automatic logic [2:0] s_of(input int i);
    return (i == 2) ? {2'b00, stall1} : stall;
  endfunction

  function automatic logic [2:0] f_of(input int i);
    return (i == 2) ? {2'b00, flush1} : flush;
  endfunction

  function automatic logic [2:0] pack_v(input int i);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < m_n[i]; k++) r[k] = m_v[i][k];
    return r;
  endfunction

  function automatic logic [23:0] pack_c(input int i);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < m_n[i]; k++) r[k*8 +: 8] = m_c[i][k];
    return r;
  endfunction

  task automatic model_comb(input int i, output logic rdy, output logic ret);
    logic [2:0] s;
    logic [2:0] f;
    int n;
    s = s_of(i);
    f = f_of(i);
    n = m_n[i];
    rdy = 1'b1;
    for (int k = 0; k < n; k++) if (s[k]) rdy = 1'b0;
    ret = m_v[i][n-1] && !s[n-1] && !f[n-1];
  endtask

  // The furthest-downstream stall splits the pipe: everything up to it is
  // frozen, the slot right after it empties, and the rest shifts forward.
  task automatic model_edge(input int i);
    logic [2:0] s;
    logic [2:0] f;
    logic       nv[3];
    logic [7:0] nc[3];
    logic       sv;
    logic [7:0] sc;
    logic       rdy, ret;
    int n, h;
    s = s_of(i);
    f = f_of(i);
    n = m_n[i];
    model_comb(i, rdy, ret);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_v[i][k] = 1'b0;
        m_c[i][k] = 8'h00;
      end
      m_cnt[i] = 4'd0;
    end else begin
      h = -1;
      for (int k = 0; k < n; k++) if (s[k]) h = k;
      for (int k = 0; k < n; k++) begin
        if (k <= h) begin
          nv[k] = m_v[i][k];
          nc[k] = m_c[i][k];
        end else if (h >= 0 && k == h + 1) begin
          nv[k] = 1'b0;
          nc[k] = 8'h00;
        end else begin
          sv = (k == 0) ? valid_d : m_v[i][k-1];
          sc = (k == 0) ? ctrl_d  : m_c[i][k-1];
          nv[k] = sv;
          nc[k] = sv ? (sc & m_keep[i][k]) : 8'h00;
        end
        if (f[k]) begin
          nv[k] = 1'b0;
          nc[k] = 8'h00;
        end
      end
      for (int k = 0; k < n; k++) begin
        m_v[i][k] = nv[k];
        m_c[i][k] = nc[k];
      end
      if (cnt_clr) m_cnt[i] = 4'd0;
      else if (ret) m_cnt[i] = m_cnt[i] + 4'd1;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: combinational checks at negedge, model update, registered
  // checks 1 time unit after the rising edge. Inputs must already be set.
  task automatic cycle();
    logic rdy, ret;
    logic [7:0] e;
    @(negedge clk);
    model_comb(0, rdy, ret);
    chk("a_in_ready", {31'b0, a_in_ready}, {31'b0, rdy});
    chk("a_retire", {31'b0, a_retire}, {31'b0, ret});
    if (ret) exp_q.push_back(m_c[0][2]);
    if (a_retire) begin
      if (exp_q.size() == 0) begin
        chk("a_retire_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("a_retired_ctrl", {24'b0, a_ctrl_q[23:16]}, {24'b0, e});
      end
    end
    model_comb(1, rdy, ret);
    chk("b_in_ready", {31'b0, b_in_ready}, {31'b0, rdy});
    chk("b_retire", {31'b0, b_retire}, {31'b0, ret});
    model_comb(2, rdy, ret);
    chk("c_in_ready", {31'b0, c_in_ready}, {31'b0, rdy});
    chk("c_retire", {31'b0, c_retire}, {31'b0, ret});
    for (int i = 0; i < 3; i++) model_edge(i);
    @(posedge clk);
    #1;
    chk("a_valid_q", {29'b0, a_valid_q}, {29'b0, pack_v(0)});
    chk("a_ctrl_q", {8'b0, a_ctrl_q}, {8'b0, pack_c(0)});
    chk("a_retire_cnt", {28'b0, a_retire_cnt}, {28'b0, m_cnt[0]});
    chk("b_valid_q", {29'b0, b_valid_q}, {29'b0, pack_v(1)});
    chk("b_ctrl_q", {8'b0, b_ctrl_q}, {8'b0, pack_c(1)});
    chk("b_retire_cnt", {28'b0, b_retire_cnt}, {28'b0, m_cnt[1]});
    chk("c_valid_q", {31'b0, c_valid_q}, {31'b0, m_v[2][0]});
    chk("c_ctrl_q", {24'b0, c_ctrl_q}, {24'b0, m_c[2][0]});
    chk("c_retire_cnt", {28'b0, c_retire_cnt}, {28'b0, m_cnt[2]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] c, input logic [2:0] s,
                       input logic [2:0] f, input logic clr);
    valid_d = v;
    ctrl_d  = c;
    stall   = s;
    flush   = f;
    cnt_clr = clr;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  c;
    logic [2:0]  s;
    logic [2:0]  f;
    logic        clr;
    logic        rdy;
    logic [2:0]  ev;
    logic [23:0] ec;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        m_v[i][k] = 1'b0;
        m_c[i][k] = 8'h00;
        m_keep[i][k] = 8'hFF;
      end
      m_cnt[i] = 4'd0;
    end
    m_keep[1][2] = 8'h0F;
    m_n[0] = 3;
    m_n[1] = 3;
    m_n[2] = 1;

    // streaming, stall with bubble, flush over stall, clear
    vecs[0]  = '{1'b1, 8'h11, 3'b000, 3'b000, 1'b0, 1'b1, 3'b001, 24'h000011, 4'd0};
    vecs[1]  = '{1'b1, 8'h22, 3'b000, 3'b000, 1'b0, 1'b1, 3'b011, 24'h001122, 4'd0};
    vecs[2]  = '{1'b1, 8'h33, 3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 24'h112233, 4'd0};
    vecs[3]  = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b1, 3'b110, 24'h223300, 4'd1};
    vecs[4]  = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b1, 3'b100, 24'h330000, 4'd2};
    vecs[5]  = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 24'h000000, 4'd3};
    vecs[6]  = '{1'b1, 8'hA5, 3'b000, 3'b000, 1'b0, 1'b1, 3'b001, 24'h0000A5, 4'd3};
    vecs[7]  = '{1'b1, 8'hB6, 3'b000, 3'b000, 1'b0, 1'b1, 3'b011, 24'h00A5B6, 4'd3};
    vecs[8]  = '{1'b1, 8'hC7, 3'b010, 3'b000, 1'b0, 1'b0, 3'b011, 24'h00A5B6, 4'd3};
    vecs[9]  = '{1'b1, 8'hC7, 3'b010, 3'b000, 1'b0, 1'b0, 3'b011, 24'h00A5B6, 4'd3};
    vecs[10] = '{1'b1, 8'hC7, 3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 24'hA5B6C7, 4'd3};
    vecs[11] = '{1'b1, 8'h5C, 3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 24'hB6C75C, 4'd4};
    vecs[12] = '{1'b1, 8'hD8, 3'b001, 3'b001, 1'b0, 1'b0, 3'b100, 24'hC70000, 4'd5};
    vecs[13] = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 24'h000000, 4'd6};
    vecs[14] = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 24'h000000, 4'd0};

    rst = 1'b1;
    stall1 = 1'b0;
    flush1 = 1'b0;
    drive(1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid_q", {29'b0, a_valid_q}, 32'd0);
    chk("reset_ctrl_q", {8'b0, a_ctrl_q}, 32'd0);
    chk("reset_retire_cnt", {28'b0, a_retire_cnt}, 32'd0);
    chk("reset_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("reset_retire", {31'b0, a_retire}, 32'd0);
    chk("reset_c_valid_q", {31'b0, c_valid_q}, 32'd0);

    for (int r = 0; r < 15; r++) begin
      drive(vecs[r].v, vecs[r].c, vecs[r].s, vecs[r].f, vecs[r].clr);
      #1;
      chk($sformatf("vec%0d_in_ready", r), {31'b0, a_in_ready}, {31'b0, vecs[r].rdy});
      cycle();
      chk($sformatf("vec%0d_valid_q", r), {29'b0, a_valid_q}, {29'b0, vecs[r].ev});
      chk($sformatf("vec%0d_ctrl_q", r), {8'b0, a_ctrl_q}, {8'b0, vecs[r].ec});
      chk($sformatf("vec%0d_retire_cnt", r), {28'b0, a_retire_cnt}, {28'b0, vecs[r].ecnt});
    end

    // pruning: stage 2 of dut_b keeps only the low nibble
    drive(1'b1, 8'hFF, 3'b000, 3'b000, 1'b0);
    cycle();
    chk("prune_s0", {24'b0, b_ctrl_q[7:0]}, 32'hFF);
    drive(1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
    cycle();
    chk("prune_s1", {24'b0, b_ctrl_q[15:8]}, 32'hFF);
    cycle();
    chk("prune_s2", {24'b0, b_ctrl_q[23:16]}, 32'h0F);
    chk("noprune_s2", {24'b0, a_ctrl_q[23:16]}, 32'hFF);

    // clear coinciding with a retire
    drive(1'b0, 8'h00, 3'b000, 3'b000, 1'b1);
    #1;
    chk("clr_retire_live", {31'b0, a_retire}, 32'd1);
    cycle();
    chk("clr_with_retire", {28'b0, a_retire_cnt}, 32'd0);

    // 17 retires on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 3'b000, 3'b000, 1'b0);
      cycle();
    end
    drive(1'b0, 8'h00, 3'b000, 3'b000, 1'b0);
    repeat (3) cycle();
    chk("wrap_a", {28'b0, a_retire_cnt}, 32'd1);
    chk("wrap_b", {28'b0, b_retire_cnt}, 32'd1);

    // reset with a full pipe and a write-back stall
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h40 + 8'(i), 3'b000, 3'b000, 1'b0);
      cycle();
    end
    chk("full_before_rst", {29'b0, a_valid_q}, 32'd7);
    rst = 1'b1;
    drive(1'b1, 8'h77, 3'b100, 3'b000, 1'b0);
    cycle();
    rst = 1'b0;
    chk("rst_mid_valid", {29'b0, a_valid_q}, 32'd0);
    chk("rst_mid_ctrl", {8'b0, a_ctrl_q}, 32'd0);
    chk("rst_mid_cnt", {28'b0, a_retire_cnt}, 32'd0);
    exp_q.delete();

    // randomized run against the model
    for (int i = 0; i < 500; i++) begin
      logic [2:0] s, f;
      for (int k = 0; k < 3; k++) begin
        s[k] = ($urandom_range(0, 99) < 15);
        f[k] = ($urandom_range(0, 99) < 8);
      end
      drive($urandom_range(0, 99) < 70, 8'($urandom_range(0, 255)), s, f,
            $urandom_range(0, 99) < 3);
      stall1 = ($urandom_range(0, 99) < 20);
      flush1 = ($urandom_range(0, 99) < 10);
      rst = ($urandom_range(0, 199) == 0);
      if (rst) exp_q.delete();
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
